snn_input_loader: RTL and testbench

SNN_INPUT_LOADER -- requirements
Module: snn_input_loader

---
 rtl/snn_input_loader.sv | 109 ++++++++++
 tb/tb_snn_input_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_input_loader.sv
// Unpacks 784 pixel bits from 98 received bytes into the input-unit RAM, starts the core,
// then sends the result over the UART. `SNN_LOADER_ASCII_EN selects ASCII result encoding.
module snn_input_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [9:0] ram_addr,
  output logic       ram_d,
  output logic       ram_we,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [3:0] digit,
  output logic       busy
);

  typedef enum logic [2:0] {
    LOAD,
    WRITE,
    START,
    WAIT_DONE,
    TX,
    TX_WAIT
  } state_t;

  localparam logic [9:0] LAST_PIXEL = 10'd783;

  state_t     state;
  logic [9:0] pix_cnt;
  logic [7:0] shift;
  logic [7:0] tx_code;

`ifdef SNN_LOADER_ASCII_EN
  assign tx_code = 8'h30 + {4'b0000, digit};
`else
  assign tx_code = {4'b0000, digit};
`endif

  assign busy = (state != LOAD);

  // Bytes always start on an 8-pixel boundary, so the low three counter bits mark the 8th bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      pix_cnt    <= '0;
      shift      <= '0;
      digit      <= '0;
      ram_we     <= 1'b0;
      ram_d      <= 1'b0;
      ram_addr   <= '0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
    end else begin
      ram_we     <= 1'b0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      case (state)
        LOAD: begin
          if (rx_rdy) begin
            shift <= rx_data;
            state <= WRITE;
          end
        end
        WRITE: begin
          ram_we   <= 1'b1;
          ram_d    <= shift[0];
          ram_addr <= pix_cnt;
          shift    <= {1'b0, shift[7:1]};
          pix_cnt  <= pix_cnt + 10'd1;
          if (pix_cnt[2:0] == 3'd7) begin
            if (pix_cnt == LAST_PIXEL) begin
              state <= START;
            end else begin
              state <= LOAD;
            end
          end
        end
        START: begin
          core_start <= 1'b1;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (core_done) begin
            digit <= core_digit;
            state <= TX;
          end
        end
        TX: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= tx_code;
            state    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          pix_cnt <= '0;
          state   <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Bench for snn_input_loader: a pixel-queue model checks every RAM write, core_start and
// tx_start, plus directed literal checks on reset, byte unpacking and result encoding.
`timescale 1ns/1ps
module tb_snn_input_loader;

  logic       clk;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [9:0] ram_addr;
  logic       ram_d;
  logic       ram_we;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [3:0] digit;
  logic       busy;

`ifdef SNN_LOADER_ASCII_EN
  localparam logic [7:0] CODE_SEVEN = 8'h37;
`else
  localparam logic [7:0] CODE_SEVEN = 8'h07;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: pending pixel writes, pending result bytes, position in the current image
  int         exp_addr[$];
  bit         exp_d[$];
  logic [7:0] exp_tx[$];
  int         model_pix = 0;
  bit         final_pending = 0;
  int         start_pulses = 0;
  int         tx_pulses = 0;
  int         writes_total = 0;
  int         ones_total = 0;
  logic [7:0] last_tx_data = '0;
  bit         prev_busy = 0;
  int         pop_addr;
  bit         pop_d;
  bit         exp_start;

  snn_input_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .digit      (digit),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] encode(input logic [3:0] d);
`ifdef SNN_LOADER_ASCII_EN
    return 8'h30 + {4'b0000, d};
`else
    return {4'b0000, d};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pixel k*8+j of an image is bit j of its k-th accepted byte.
  task automatic modelByte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) begin
      exp_addr.push_back(model_pix + j);
      exp_d.push_back(b[j]);
    end
    model_pix += 8;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit accepted);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    if (accepted) modelByte(b);
  endtask

  task automatic waitStart(input int prev);
    for (int i = 0; i < 100 && start_pulses == prev; i++) tick(1);
    checkOutput("core_start count", 32'(start_pulses), 32'(prev + 1));
  endtask

  task automatic waitTx(input int prev);
    for (int i = 0; i < 100 && tx_pulses == prev; i++) tick(1);
    checkOutput("tx_start count", 32'(tx_pulses), 32'(prev + 1));
  endtask

  task automatic pulseDone(input logic [3:0] d, input bit in_wait_done);
    core_digit = d;
    core_done  = 1'b1;
    if (in_wait_done) begin
      exp_tx.push_back(encode(d));
      model_pix = 0;
    end
    tick(1);
    core_done = 1'b0;
  endtask

  // Compare process: every RAM write, core_start and tx_start against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      final_pending = 0;
      prev_busy     = 0;
    end else begin
      exp_start     = final_pending;
      final_pending = 0;
      if (ram_we) begin
        writes_total++;
        if (ram_d) ones_total++;
        if (exp_addr.size() == 0) begin
          checkOutput("unexpected ram_we", 32'd1, 32'd0);
        end else begin
          pop_addr = exp_addr.pop_front();
          pop_d    = exp_d.pop_front();
          checkOutput("ram_addr", 32'(ram_addr), 32'(pop_addr));
          checkOutput("ram_d", 32'(ram_d), 32'(pop_d));
          final_pending = (pop_addr == 783);
        end
      end
      checkOutput("core_start", 32'(core_start), 32'(exp_start));
      if (core_start) start_pulses++;
      if (tx_start) begin
        tx_pulses++;
        last_tx_data = tx_data;
        checkOutput("tx_start while tx_busy", 32'(prev_busy), 32'd0);
        if (exp_tx.size() == 0) checkOutput("unexpected tx_start", 32'd1, 32'd0);
        else checkOutput("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      prev_busy = tx_busy;
    end
  end

  int         we_cnt;
  int         first_addr;
  logic [7:0] bits;
  int         w0;
  int         o0;
  int         p0;

  initial begin
    rst_n      = 1'b0;
    rx_rdy     = 1'b0;
    rx_data    = '0;
    core_done  = 1'b0;
    core_digit = '0;
    tx_busy    = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checkOutput("reset ram_we", 32'(ram_we), 32'd0);
    checkOutput("reset ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("reset ram_d", 32'(ram_d), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset digit", 32'(digit), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);

    // core_done while loading must not touch digit
    pulseDone(4'd3, 1'b0);
    tick(1);
    checkOutput("core_done ignored", 32'(digit), 32'd0);

    // Image 1: first byte 0xA5 unpacked LSB first
    applyStimulus(8'hA5, 1'b1);
    we_cnt = 0;
    first_addr = -1;
    bits = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_we) begin
        if (first_addr < 0) first_addr = int'(ram_addr);
        bits = {ram_d, bits[7:1]};
        we_cnt++;
      end
    end
    tick(1);
    checkOutput("A5 write count", 32'(we_cnt), 32'd8);
    checkOutput("A5 bit order", 32'(bits), 32'h0000_00A5);
    checkOutput("A5 first addr", 32'(first_addr), 32'd0);

    for (int k = 1; k < 98; k++) begin
      applyStimulus(8'(k * 29 + 11), 1'b1);
      if (k % 10 == 3) begin
        tick(2);
        applyStimulus(8'h77, 1'b0);
        tick(7);
      end else if (k % 10 == 7) begin
        tick(7);
        applyStimulus(8'hC3, 1'b0);
        tick(2);
      end else begin
        tick(10);
      end
    end
    waitStart(0);
    tick(3);
    checkOutput("busy in wait_done", 32'(busy), 32'd1);
    applyStimulus(8'h3C, 1'b0);
    tick(3);
    p0 = tx_pulses;
    pulseDone(4'd7, 1'b1);
    waitTx(p0);
    checkOutput("digit after done", 32'(digit), 32'd7);
    checkOutput("tx_data literal", 32'(last_tx_data), 32'(CODE_SEVEN));
    tick(5);
    checkOutput("busy back in load", 32'(busy), 32'd0);

    // Image 2: all ones, next image must restart at address 0
    w0 = writes_total;
    o0 = ones_total;
    applyStimulus(8'hFF, 1'b1);
    tick(1);
    checkOutput("image2 first we", 32'(ram_we), 32'd1);
    checkOutput("image2 first addr", 32'(ram_addr), 32'd0);
    tick(9);
    for (int k = 1; k < 98; k++) begin
      applyStimulus(8'hFF, 1'b1);
      tick(10);
    end
    waitStart(1);
    checkOutput("image2 writes", 32'(writes_total - w0), 32'd784);
    checkOutput("image2 ones", 32'(ones_total - o0), 32'd784);

    // Transmitter busy for 20 cycles holds off the result byte
    tx_busy = 1'b1;
    p0 = tx_pulses;
    pulseDone(4'd4, 1'b1);
    tick(19);
    checkOutput("tx held while busy", 32'(tx_pulses), 32'(p0));
    tx_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("tx_start after busy falls", 32'(tx_start), 32'd1);
    @(negedge clk);
    checkOutput("tx_start single pulse", 32'(tx_start), 32'd0);
    tick(1);
    checkOutput("digit 4", 32'(digit), 32'd4);
    checkOutput("tx count after busy", 32'(tx_pulses), 32'(p0 + 1));
    tick(5);

    // Partial image, then reset discards it
    for (int k = 0; k < 50; k++) begin
      applyStimulus(8'(k) ^ 8'h5A, 1'b1);
      tick(10);
    end
    for (int i = 0; i < 50 && exp_addr.size() != 0; i++) tick(1);
    checkOutput("partial writes drained", 32'(exp_addr.size()), 32'd0);
    rst_n = 1'b0;
    #2;
    checkOutput("async reset digit", 32'(digit), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    exp_addr.delete();
    exp_d.delete();
    model_pix = 0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    p0 = start_pulses;
    for (int k = 0; k < 98; k++) begin
      applyStimulus(8'hC0 + 8'(k), 1'b1);
      tick(10);
    end
    waitStart(p0);
    tick(20);
    checkOutput("single core_start", 32'(start_pulses), 32'(p0 + 1));
    checkOutput("writes outstanding", 32'(exp_addr.size()), 32'd0);
    checkOutput("tx outstanding", 32'(exp_tx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
